cdce_spi_responder: RTL and testbench
=====================================

CDCE_SPI_RESPONDER -- requirements
Module: cdce_spi_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, SPI frame length in bits.
REQ-002 SHALL have parameter NUM_REGS, default 13, number of device registers (addresses 0..NUM_REGS-1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock from initiator, asynchronous to clk.
REQ-006 SHALL have port spi_sdata  input  1  SPI data from initiator (MOSI).
REQ-007 SHALL have port cdce_n_en  input  1  chip select, active-low.
REQ-008 SHALL have port cdce_miso  output  1  readback data to initiator.
REQ-009 SHALL have ports wr_strobe/wr_addr/wr_data  output  1/4/WIDTH  one-cycle pulse plus address and word of each committed register write.
REQ-010 SHALL have ports rd_addr/rd_data  input 4 / output WIDTH  combinational peek into register file for checking.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on malformed frame.

Function
REQ-012 SHALL pass spi_sclk, spi_sdata, cdce_n_en through 2-flop synchronisers, then a third flop for edge detection; clk SHALL be at least 8x sclk frequency.
REQ-013 SHALL implement states IDLE, SHIFT, COMMIT; IDLE->SHIFT on synchronised cdce_n_en fall; SHIFT->COMMIT on its rise; COMMIT->IDLE unconditionally after one cycle.
REQ-014 SHALL, in SHIFT, sample spi_sdata on each synchronised sclk rising edge into a shift register, LSB first (first bit = bit 0), and count bits with a 6-bit counter saturating at WIDTH+1.
REQ-015 SHALL, in COMMIT with count == WIDTH, decode address = word[3:0], payload = word[WIDTH-1:4].
REQ-016 SHALL, for address < NUM_REGS, store the full word into register[address] and pulse wr_strobe with wr_addr/wr_data valid in the same cycle.
REQ-017 SHALL, in COMMIT with count != WIDTH, discard the word, pulse frame_err, leave registers unchanged.
REQ-018 SHALL, for address >= NUM_REGS other than 4'hE, drop the word silently (no strobe, no error).
REQ-019 SHALL assert wr_strobe/frame_err exactly 3 clk edges after the first clk edge sampling cdce_n_en high.
REQ-020 SHALL ignore sclk edges while in IDLE or COMMIT; a cdce_n_en fall during COMMIT SHALL be acted on in the following IDLE cycle.
REQ-021 SHALL drive cdce_miso 0 whenever synchronised cdce_n_en is high.

Reset
REQ-022 SHALL, on rst, clear state to IDLE, bit counter, shift register, all registers to 0, pending readback, wr_strobe, frame_err, cdce_miso to 0.
REQ-023 SHALL, on rst asserted mid-frame, abandon the frame with no strobe or error; the frame in progress at release is ignored until the next cdce_n_en fall.

Configuration
REQ-024 SHALL use macro CDCE_SPI_RESPONDER_READBACK_EN.
REQ-025 With macro defined: a valid frame with address 4'hE SHALL latch word[7:4] as pending read target; during the next frame cdce_miso SHALL present register[target] LSB first, bit 0 from cdce_n_en fall detection, next bit after each synchronised sclk falling edge; target >= NUM_REGS returns 0; pending cleared after that frame.
REQ-026 Without macro: address 4'hE treated per REQ-018, cdce_miso tied to 0, no readback logic synthesised.

Structure
REQ-027 SHALL place WIDTH default, NUM_REGS default, READ_CMD_ADDR (4'hE), and state encoding (one-hot localparams IDLE/SHIFT/COMMIT) in a shared package cdce_pkg.
REQ-028 SHALL instantiate one sub-module sync_edge_det (2-flop sync plus rise/fall pulses), used three times.

Verification
REQ-029 Frame 32'h683C0250 (addr 0), sclk = clk/8 -> wr_strobe once, wr_addr 0, wr_data 32'h683C0250, rd_addr 0 returns it.
REQ-030 Thirteen frames addr 0..12 back-to-back, 2-clk cdce_n_en high gap -> 13 strobes in order, no frame_err.
REQ-031 31-bit frame then 33-bit frame -> two frame_err pulses, no wr_strobe, registers unchanged.
REQ-032 With macro: write 32'h0000180C to reg 12, then 32'h000000CE, then dummy frame -> miso shifts 32'h0000180C LSB first; without macro miso stays 0.
REQ-033 rst pulsed after 16 bits of a frame -> no strobe, all registers 0; next full frame commits normally.

Source files
------------

// File: rtl/cdce_pkg.sv
// Shared constants for the CDCE SPI responder: default geometry, the
// readback command address and the one-hot frame-state encoding.
package cdce_pkg;

    localparam int CDCE_WIDTH    = 32;
    localparam int CDCE_NUM_REGS = 13;

    // Frames addressed here arm a readback instead of writing a register.
    localparam logic [3:0] READ_CMD_ADDR = 4'hE;

    // One-hot frame states.
    localparam logic [2:0] IDLE   = 3'b001;
    localparam logic [2:0] SHIFT  = 3'b010;
    localparam logic [2:0] COMMIT = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_SHIFT  = SHIFT,
        ST_COMMIT = COMMIT
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, plus a third flop so
// single-cycle rise/fall pulses can be derived from the synchronised level.
// All flops reset low so a line held low at reset release produces no fall.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Synchroniser chain and edge-history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
    assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/cdce_spi_responder.sv
// SPI responder emulating the CDCE register interface: receives LSB-first
// frames, commits full-length frames into a small register file and flags
// malformed frames. Optional readback is enabled by defining
// CDCE_SPI_RESPONDER_READBACK_EN.
module cdce_spi_responder
    import cdce_pkg::*;
#(
    parameter int WIDTH    = CDCE_WIDTH,
    parameter int NUM_REGS = CDCE_NUM_REGS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_sdata,
    input  logic             cdce_n_en,
    output logic             cdce_miso,
    output logic             wr_strobe,
    output logic [3:0]       wr_addr,
    output logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             frame_err
);

    localparam logic [5:0] CNT_FULL = 6'(WIDTH);
    localparam logic [5:0] CNT_MAX  = 6'(WIDTH + 1);
    localparam logic [4:0] NREGS    = 5'(NUM_REGS);

    logic sclk_level, sclk_rise, sclk_fall;
    logic sdata_level, sdata_rise, sdata_fall;
    logic cs_level, cs_rise, cs_fall;

    state_t           state_reg, state_next;
    logic [5:0]       cnt_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic             fall_pend_reg;
    logic             wr_strobe_reg, frame_err_reg;
    logic [3:0]       wr_addr_reg;
    logic [WIDTH-1:0] wr_data_reg;
    logic [WIDTH-1:0] regs_reg [NUM_REGS];

    logic       frame_start, commit_ok, addr_in_range, read_cmd, reg_we;
    logic [3:0] frame_addr;

    sync_edge_det u_sync_sclk  (.clk(clk), .rst(rst), .d(spi_sclk),
                                .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge_det u_sync_sdata (.clk(clk), .rst(rst), .d(spi_sdata),
                                .level(sdata_level), .rise(sdata_rise), .fall(sdata_fall));
    sync_edge_det u_sync_cs    (.clk(clk), .rst(rst), .d(cdce_n_en),
                                .level(cs_level), .rise(cs_rise), .fall(cs_fall));

    // A chip-select fall seen during COMMIT is remembered in fall_pend_reg and
    // starts the frame from the following IDLE cycle.
    assign frame_start   = (state_reg == ST_IDLE) && (cs_fall || fall_pend_reg);
    assign frame_addr    = shreg_reg[3:0];
    assign commit_ok     = (state_reg == ST_COMMIT) && (cnt_reg == CNT_FULL);
    assign addr_in_range = ({1'b0, frame_addr} < NREGS);
`ifdef CDCE_SPI_RESPONDER_READBACK_EN
    assign read_cmd      = commit_ok && (frame_addr == READ_CMD_ADDR);
`else
    assign read_cmd      = 1'b0;
`endif
    assign reg_we        = commit_ok && addr_in_range && !read_cmd;

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: open on CS fall, close on CS rise, one COMMIT cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (frame_start) state_next = ST_SHIFT;
            ST_SHIFT:  if (cs_rise)     state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Bit capture, saturating bit count and registered write/error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            fall_pend_reg <= 1'b0;
            wr_strobe_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            wr_strobe_reg <= reg_we;
            frame_err_reg <= (state_reg == ST_COMMIT) && (cnt_reg != CNT_FULL);
            fall_pend_reg <= (state_reg == ST_COMMIT) && cs_fall;
            if (reg_we) begin
                wr_addr_reg <= frame_addr;
                wr_data_reg <= shreg_reg;
            end
            if (frame_start) begin
                cnt_reg   <= '0;
                shreg_reg <= '0;
            end else if ((state_reg == ST_SHIFT) && sclk_rise) begin
                shreg_reg <= {sdata_level, shreg_reg[WIDTH-1:1]};
                if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 6'd1;
            end
        end
    end

    // Register file: one word per address, each with its own write decode.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [WIDTH-1:0] word_reg;

        // Capture the committed word when this address is selected.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                   word_reg <= '0;
            else if (reg_we && (frame_addr == 4'(gi))) word_reg <= shreg_reg;
        end

        assign regs_reg[gi] = word_reg;
    end

    assign rd_data = ({1'b0, rd_addr} < NREGS) ? regs_reg[rd_addr] : '0;

`ifdef CDCE_SPI_RESPONDER_READBACK_EN
    logic [WIDTH-1:0] miso_sh_reg;
    logic [3:0]       rb_target_reg;
    logic             rb_pend_reg;
    logic             rb_serving_reg;

    // Readback: arm on a read command, load the target word at the next frame
    // start, shift it out on sclk falls, disarm when that frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_sh_reg    <= '0;
            rb_target_reg  <= '0;
            rb_pend_reg    <= 1'b0;
            rb_serving_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                miso_sh_reg    <= (rb_pend_reg && ({1'b0, rb_target_reg} < NREGS))
                                  ? regs_reg[rb_target_reg] : '0;
                rb_serving_reg <= rb_pend_reg;
            end else if ((state_reg == ST_SHIFT) && sclk_fall) begin
                miso_sh_reg <= miso_sh_reg >> 1;
            end
            if (state_reg == ST_COMMIT && rb_serving_reg) begin
                rb_pend_reg    <= 1'b0;
                rb_serving_reg <= 1'b0;
            end
            if (read_cmd) begin
                rb_pend_reg   <= 1'b1;
                rb_target_reg <= shreg_reg[7:4];
            end
        end
    end

    assign cdce_miso = ~cs_level & miso_sh_reg[0];
`else
    assign cdce_miso = 1'b0;
`endif

    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign frame_err = frame_err_reg;

    // Synchroniser outputs not needed by this configuration.
    wire unused_ok = &{1'b0, sclk_level, sclk_fall, sdata_rise, sdata_fall};

endmodule

// File: tb/tb_cdce_spi_responder.sv
// Directed bench for cdce_spi_responder: table of single frames plus
// hand-written sequences for latency, back-to-back, readback and reset.
module tb_cdce_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk, spi_sdata, cdce_n_en;
    logic        cdce_miso, wr_strobe, frame_err;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;

    cdce_spi_responder dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_sdata(spi_sdata),
        .cdce_n_en(cdce_n_en), .cdce_miso(cdce_miso), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;
    logic [3:0]  last_addr;
    logic [31:0] last_data;
    logic [3:0]  addr_q[$];
    logic [31:0] data_q[$];
    logic [31:0] model [13];

    // Record every write strobe and error pulse away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
            addr_q.push_back(wr_addr);
            data_q.push_back(wr_data);
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 13; r++) begin
            rd_addr = 4'(r);
            #1;
            check($sformatf("%s_reg%0d", tag, r), 64'(rd_data), 64'(model[r]));
        end
    endtask

    // Drive n bits LSB first at sclk = clk/8; CS is left low afterwards.
    // The miso value is sampled just before each sclk rise.
    task automatic send_bits(input logic [63:0] d, input int n, output logic [63:0] mb);
        mb = '0;
        cdce_n_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_sdata = d[i];
            repeat (4) @(negedge clk);
            mb[i] = cdce_miso;
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame(input int gap);
        cdce_n_en = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    typedef struct {
        logic [63:0] data;
        int          nbits;
        logic        exp_strobe;
        logic [3:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];
    logic [63:0] mb;
    logic [31:0] exp_rb;
    int s0, e0;

    initial begin
        vecs[0] = '{64'h683C0250,   32, 1'b1, 4'h0, 32'h683C0250, 1'b0};
        vecs[1] = '{64'h12345671,   32, 1'b1, 4'h1, 32'h12345671, 1'b0};
        vecs[2] = '{64'hDEADBEEC,   32, 1'b1, 4'hC, 32'hDEADBEEC, 1'b0};
        vecs[3] = '{64'hCAFEF00D,   32, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[4] = '{64'h0000000F,   32, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[5] = '{64'hA5A5A5A3,   31, 1'b0, 4'h0, 32'h0,        1'b1};
        vecs[6] = '{64'h15A5A5A52,  33, 1'b0, 4'h0, 32'h0,        1'b1};
        vecs[7] = '{64'h000000CE,   32, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[8] = '{64'h00000003,   32, 1'b1, 4'h3, 32'h00000003, 1'b0};
        for (int r = 0; r < 13; r++) model[r] = '0;

        rst = 1'b1; cdce_n_en = 1'b1; spi_sclk = 1'b0; spi_sdata = 1'b0; rd_addr = '0;
        repeat (4) @(negedge clk);
        check("reset_strobe", 64'(wr_strobe), 64'h0);
        check("reset_err",    64'(frame_err), 64'h0);
        check("reset_miso",   64'(cdce_miso), 64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_regs("reset");

        // Single write with exact strobe latency after CS rise.
        send_bits(64'h683C0250, 32, mb);
        cdce_n_en = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_strobe_early", 64'(wr_strobe), 64'h0);
        @(negedge clk);
        check("lat_strobe", 64'(wr_strobe), 64'h1);
        check("lat_addr",   64'(wr_addr),   64'h0);
        check("lat_data",   64'(wr_data),   64'h683C0250);
        @(negedge clk);
        check("lat_strobe_width", 64'(wr_strobe), 64'h0);
        repeat (4) @(negedge clk);
        check("lat_strobe_total", 64'(strobe_cnt), 64'd1);
        model[0] = 32'h683C0250;
        check_regs("single");
        $display("frame single data=0x683C0250 bits=32 strobes=%0d", strobe_cnt);

        // Error pulse latency on a short frame.
        send_bits(64'h7, 31, mb);
        cdce_n_en = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_err_early", 64'(frame_err), 64'h0);
        @(negedge clk);
        check("lat_err", 64'(frame_err), 64'h1);
        repeat (6) @(negedge clk);
        $display("frame short data=0x7 bits=31 errors=%0d", err_cnt);

        // Table of single frames.
        for (int k = 0; k < 9; k++) begin
            s0 = strobe_cnt; e0 = err_cnt;
            send_bits(vecs[k].data, vecs[k].nbits, mb);
            end_frame(10);
            $display("frame vec%0d data=0x%0h bits=%0d strobes=%0d errors=%0d",
                     k, vecs[k].data, vecs[k].nbits, strobe_cnt - s0, err_cnt - e0);
            check($sformatf("vec%0d_strobes", k), 64'(strobe_cnt - s0), 64'(vecs[k].exp_strobe));
            check($sformatf("vec%0d_errors", k),  64'(err_cnt - e0),    64'(vecs[k].exp_err));
            check($sformatf("vec%0d_miso_idle", k), 64'(cdce_miso), 64'h0);
            if (vecs[k].exp_strobe) begin
                check($sformatf("vec%0d_addr", k), 64'(last_addr), 64'(vecs[k].exp_addr));
                check($sformatf("vec%0d_data", k), 64'(last_data), 64'(vecs[k].exp_data));
                model[vecs[k].exp_addr] = vecs[k].exp_data;
            end
            check_regs($sformatf("vec%0d", k));
        end

        // Thirteen back-to-back writes with a two-cycle CS-high gap.
        s0 = strobe_cnt; e0 = err_cnt;
        addr_q.delete(); data_q.delete();
        for (int a = 0; a < 13; a++) begin
            send_bits(64'(32'hB0000000 | (a << 8) | a), 32, mb);
            end_frame((a == 12) ? 10 : 2);
            $display("frame b2b addr=%0d", a);
        end
        check("b2b_strobes", 64'(strobe_cnt - s0), 64'd13);
        check("b2b_errors",  64'(err_cnt - e0),    64'd0);
        for (int a = 0; a < 13; a++) begin
            if (a < addr_q.size()) begin
                check($sformatf("b2b_addr%0d", a), 64'(addr_q[a]), 64'(a));
                check($sformatf("b2b_data%0d", a), 64'(data_q[a]), 64'(32'hB0000000 | (a << 8) | a));
            end
            model[a] = 32'hB0000000 | (a << 8) | a;
        end
        check_regs("b2b");

        // Readback: write reg 12, arm read of reg 12, then two dummy frames.
`ifdef CDCE_SPI_RESPONDER_READBACK_EN
        exp_rb = 32'h0000180C;
`else
        exp_rb = 32'h0;
`endif
        send_bits(64'h0000180C, 32, mb); end_frame(10);
        model[12] = 32'h0000180C;
        send_bits(64'h000000CE, 32, mb); end_frame(10);
        send_bits(64'h0000000F, 32, mb); end_frame(10);
        $display("frame readback miso=0x%0h", mb[31:0]);
        check("readback_miso", 64'(mb[31:0]), 64'(exp_rb));
        send_bits(64'h0000000F, 32, mb); end_frame(10);
        $display("frame after_readback miso=0x%0h", mb[31:0]);
        check("readback_cleared", 64'(mb[31:0]), 64'h0);
        check_regs("readback");

        // Reset in the middle of a frame.
        s0 = strobe_cnt; e0 = err_cnt;
        send_bits(64'h11111111, 16, mb);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_bits(64'h1111, 16, mb);
        end_frame(10);
        $display("frame reset_mid strobes=%0d errors=%0d", strobe_cnt - s0, err_cnt - e0);
        check("rstmid_strobes", 64'(strobe_cnt - s0), 64'd0);
        check("rstmid_errors",  64'(err_cnt - e0),    64'd0);
        for (int r = 0; r < 13; r++) model[r] = '0;
        check_regs("rstmid");
        send_bits(64'h683C0250, 32, mb);
        end_frame(10);
        $display("frame post_reset strobes=%0d", strobe_cnt - s0);
        check("postrst_strobes", 64'(strobe_cnt - s0), 64'd1);
        check("postrst_data",    64'(last_data),       64'h683C0250);
        model[0] = 32'h683C0250;
        check_regs("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
